regfile_read_arbiter: RTL and testbench

- Shares the single 32-entry register-file read path (external 32:1 read mux) between NREQ requesters plus one internal dump agent.
- Per cycle: picks one winner, drives the mux select, registers the returned word.
- Dump agent walks r0..r31 for the debug/display path.
- Sits between pipeline ID-stage/debug requesters and the register-file read mux.

---
 rtl/regfile_read_arbiter_pkg.sv | 11 +
 rtl/regfile_read_arbiter_rr_arbiter.sv | 31 +++
 rtl/regfile_read_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_read_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/regfile_read_arbiter_pkg.sv
// Shared constants and dump-FSM encodings for the register-file read arbiter.
package regfile_read_arbiter_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } dump_state_e;
endpackage

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// NREQ-wide round-robin picker: searches upward from ptr_i, wrapping, first set req wins.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  logic [IW:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(k);
      if (pos >= NREQ_W) pos = pos - NREQ_W;
      if (!any_o && req_i[pos[IW-1:0]]) begin
        any_o                = 1'b1;
        gnt_o[pos[IW-1:0]]   = 1'b1;
        idx_o                = pos[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register-file read mux between NREQ requesters and a lowest-priority
// dump agent that sweeps r0..r31; the returned word is registered one cycle later.
module regfile_read_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [AW-1:0]     dump_idx_q,
  output logic [AW-1:0]     mux_sel,
  input  logic [DW-1:0]     mux_data
);
  import regfile_read_arbiter_pkg::*;

  localparam int          IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  dump_state_e       state_q, state_d;
  logic [AW-1:0]     didx_q, didx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   rvalid_q;
  logic [DW-1:0]     rdata_q;
  logic              dump_valid_q;

  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     win_idx;
  logic              arb_any;
  logic              ext_win;
  logic              dump_gnt;
  logic [IW:0]       ptr_inc;
  logic [AW-1:0]     addr_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_addr
    assign addr_a[g] = addr[g*AW +: AW];
  end

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (win_idx),
    .any_o (arb_any)
  );

  // Nothing is granted while reset is asserted, so no rvalid can follow it.
  assign ext_win   = rst_n && arb_any;
  assign dump_gnt  = rst_n && (req == '0) && (state_q == DUMP);
  assign gnt       = ext_win ? arb_gnt : '0;
  assign dump_busy = (state_q == DUMP);

  always_comb begin
    mux_sel = '0;
    if (ext_win)       mux_sel = addr_a[win_idx];
    else if (dump_gnt) mux_sel = didx_q;
  end

  always_comb begin
    ptr_inc = {1'b0, win_idx} + 1'b1;
    ptr_d   = (ptr_inc == NREQ_W) ? '0 : ptr_inc[IW-1:0];
  end

  always_comb begin
    state_d = state_q;
    didx_d  = didx_q;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = DUMP;
          didx_d  = '0;
        end
      end
      DUMP: begin
        // Last register ends the sweep; no wrap into a second pass.
        if (dump_gnt) begin
          if (didx_q == {AW{1'b1}}) begin
            state_d = IDLE;
            didx_d  = '0;
          end else begin
            didx_d = didx_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      didx_q       <= '0;
      ptr_q        <= '0;
      rvalid_q     <= '0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      didx_q       <= didx_d;
      rvalid_q     <= gnt;
      dump_valid_q <= dump_gnt;
      dump_idx_q   <= didx_q;
      if (ext_win) ptr_q <= ptr_d;
      if (ext_win || dump_gnt)
        rdata_q <= (mux_sel == REG_ZERO) ? '0 : mux_data;
    end
  end

  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign dump_valid = dump_valid_q;
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a one-deep return-path scoreboard.
module tb_regfile_read_arbiter;
  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ*AW-1:0]  addr;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rvalid;
  logic [DW-1:0]       rdata;
  logic                dump_start;
  logic                dump_busy;
  logic                dump_valid;
  logic [AW-1:0]       dump_idx_q;
  logic [AW-1:0]       mux_sel;
  logic [DW-1:0]       mux_data;

  always #5 clk = ~clk;

  regfile_read_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .addr       (addr),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_idx_q (dump_idx_q),
    .mux_sel    (mux_sel),
    .mux_data   (mux_data)
  );

  typedef struct {
    logic [NREQ-1:0] rv;
    logic [DW-1:0]   rd;
    logic            dv;
    logic [AW-1:0]   di;
  } ret_t;

  ret_t        sbq[$];
  logic [DW-1:0] exp_rd;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; check combinational outputs, queue the expected
  // return, clock once and compare the registered outputs against the queue head.
  task automatic step(input logic [NREQ-1:0] eg, input logic edg,
                      input logic [AW-1:0] esel, input logic ebusy);
    ret_t e;
    #1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("mux_sel", 32'(mux_sel), 32'(esel));
    chk("dump_busy", 32'(dump_busy), 32'(ebusy));
    if (!rst_n)               exp_rd = '0;
    else if (eg != '0 || edg) exp_rd = (esel == '0) ? '0 : mux_data;
    e.rv = rst_n ? eg : '0;
    e.dv = rst_n && edg;
    e.di = esel;
    e.rd = exp_rd;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("rvalid", 32'(rvalid), 32'(e.rv));
    chk("rdata", rdata, e.rd);
    chk("dump_valid", 32'(dump_valid), 32'(e.dv));
    if (e.dv) chk("dump_idx_q", 32'(dump_idx_q), 32'(e.di));
  endtask

  initial begin
    rst_n = 1'b0; req = '0; addr = '0; mux_data = '0; dump_start = 1'b0; exp_rd = '0;
    @(posedge clk);
    #1;
    step('0, 1'b0, '0, 1'b0);
    // a request during reset must not be granted
    req = 2'b01; addr = {5'd0, 5'd9}; mux_data = 32'h1111_1111;
    step('0, 1'b0, '0, 1'b0);

    rst_n = 1'b1; req = '0;
    repeat (10) step('0, 1'b0, '0, 1'b0);

    req = 2'b01; addr = {5'd0, 5'd7}; mux_data = 32'hDEAD_BEEF;
    step(2'b01, 1'b0, 5'd7, 1'b0);
    req = '0; mux_data = 32'h1234_5678;
    step('0, 1'b0, '0, 1'b0);

    req = 2'b10; addr = {5'd0, 5'd7}; mux_data = 32'hFFFF_FFFF;
    step(2'b10, 1'b0, 5'd0, 1'b0);

    req = 2'b11; addr = {5'd4, 5'd3};
    for (int i = 0; i < 4; i++) begin
      mux_data = 32'hC0DE_0000 + 32'(i);
      step((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, (i % 2 == 0) ? 5'd3 : 5'd4, 1'b0);
    end

    req = '0; dump_start = 1'b1;
    step('0, 1'b0, '0, 1'b0);
    dump_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      mux_data = 32'hA5A5_0000 | 32'(k);
      step('0, 1'b1, 5'(k), 1'b1);
    end
    step('0, 1'b0, '0, 1'b0);

    // sweep start coinciding with an external request
    req = 2'b10; addr = {5'd2, 5'd0}; mux_data = 32'h2222_2222; dump_start = 1'b1;
    step(2'b10, 1'b0, 5'd2, 1'b0);
    dump_start = 1'b0; req = '0;
    for (int k = 0; k < 10; k++) begin
      mux_data = 32'hB000_0000 | 32'(k);
      dump_start = (k == 4);
      step('0, 1'b1, 5'(k), 1'b1);
    end
    dump_start = 1'b0;
    req = 2'b01; addr = {5'd0, 5'd5};
    for (int k = 0; k < 3; k++) begin
      mux_data = 32'h5555_0000 + 32'(k);
      step(2'b01, 1'b0, 5'd5, 1'b1);
    end
    req = '0;
    for (int k = 10; k < 12; k++) begin
      mux_data = 32'hB000_0000 | 32'(k);
      step('0, 1'b1, 5'(k), 1'b1);
    end

    rst_n = 1'b0;
    step('0, 1'b0, '0, 1'b1);
    rst_n = 1'b1;
    step('0, 1'b0, '0, 1'b0);
    dump_start = 1'b1;
    step('0, 1'b0, '0, 1'b0);
    dump_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mux_data = 32'hC000_0000 | 32'(k);
      step('0, 1'b1, 5'(k), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
